// File: rtl/gpr_wb_pkg.sv
// Shared constants, requester IDs and register-file types for the GPR write-back arbiter.
package gpr_wb_pkg;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 3;
    localparam int NUM_REQ = 3;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_DBG = 2;

    typedef logic [ADDR_W-1:0] gpr_addr_t;
    typedef logic [DATA_W-1:0] gpr_data_t;

    // Index following idx in a ring of n requesters.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Grant selection for the write-back port: round-robin from ptr, or strict
// index-0-first priority when GPR_WB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               hold,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         ptr_next
);
    import gpr_wb_pkg::*;

    int   start;
    int   cand;
    logic found;

    always_comb begin
        grant    = '0;
        ptr_next = ptr;
        found    = 1'b0;
        cand     = 0;
`ifdef GPR_WB_FIXED_PRIO_EN
        start    = 0;
`else
        start    = int'(ptr);
`endif
        if (!hold) begin
            for (int off = 0; off < NUM_REQ; off++) begin
                cand = start + off;
                if (cand >= NUM_REQ) begin
                    cand = cand - NUM_REQ;
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!found && i == cand && req_valid[i]) begin
                        grant[i] = 1'b1;
                        found    = 1'b1;
`ifdef GPR_WB_FIXED_PRIO_EN
                        ptr_next = 2'd0;
`else
                        ptr_next = 2'(rr_next(i, NUM_REQ));
`endif
                    end
                end
            end
        end
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Shares the register-file write port among NUM_REQ valid/ready requesters and
// registers the winner onto the port. Optional macro: GPR_WB_FIXED_PRIO_EN.
module gpr_wb_arbiter #(
    parameter int NUM_REQ = gpr_wb_pkg::NUM_REQ,
    parameter int DATA_W  = gpr_wb_pkg::DATA_W,
    parameter int ADDR_W  = gpr_wb_pkg::ADDR_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_dest,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic                        wb_hold,
    output logic                        reg_write_en,
    output logic [ADDR_W-1:0]           reg_write_dest,
    output logic [DATA_W-1:0]           reg_write_data,
    output logic [1:0]                  grant_id,
    output logic                        arb_idle
);
    import gpr_wb_pkg::*;

    logic [1:0]         ptr;
    logic [1:0]         ptr_next;
    logic [NUM_REQ-1:0] grant;
    logic               transfer;
    logic [ADDR_W-1:0]  sel_dest;
    logic [DATA_W-1:0]  sel_data;
    logic [1:0]         sel_id;

    // Reset acts as a hold so nothing is granted while it is asserted.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_valid (req_valid),
        .hold      (wb_hold | rst),
        .ptr       (ptr),
        .grant     (grant),
        .ptr_next  (ptr_next)
    );

    assign req_ready = grant;
    assign transfer  = |grant;

    always_comb begin
        sel_dest = '0;
        sel_data = '0;
        sel_id   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_dest = req_dest[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
                sel_id   = 2'(i);
            end
        end
    end

    // Output stage: dest/data/id keep their last value between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr            <= '0;
            reg_write_en   <= 1'b0;
            reg_write_dest <= '0;
            reg_write_data <= '0;
            grant_id       <= '0;
        end else begin
            ptr          <= ptr_next;
            reg_write_en <= transfer;
            if (transfer) begin
                reg_write_dest <= sel_dest;
                reg_write_data <= sel_data;
                grant_id       <= sel_id;
            end
        end
    end

    assign arb_idle = ~|req_valid & ~reg_write_en;

endmodule
